// File: rtl/trig_capture_if.sv
// Port bundle for trig_capture: sample stream, capture control/status and readout.
// FORCE_TRIG_EN adds the force_trig control line.
interface trig_capture_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 10
);
  // sample_valid is a one-cycle strobe qualifying adc_data (no back-pressure);
  // each rd_en accepted in DONE is answered one cycle later by rd_valid with rd_data.
  logic [DATA_W-1:0]     adc_data;
  logic                  sample_valid;
  logic                  arm;
  logic [DATA_W-1:0]     trig_level;
  logic                  trig_falling;
  logic [DEPTH_LOG2-1:0] pretrig;
`ifdef FORCE_TRIG_EN
  logic                  force_trig;
`endif
  logic                  busy;
  logic                  triggered;
  logic                  done;
  logic                  rd_en;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic [2:0]            dbg_state;

  modport master (
`ifdef FORCE_TRIG_EN
    output force_trig,
`endif
    output adc_data, sample_valid, arm, trig_level, trig_falling, pretrig, rd_en,
    input  busy, triggered, done, rd_data, rd_valid, rd_last, dbg_state
  );

  modport slave (
`ifdef FORCE_TRIG_EN
    input  force_trig,
`endif
    input  adc_data, sample_valid, arm, trig_level, trig_falling, pretrig, rd_en,
    output busy, triggered, done, rd_data, rd_valid, rd_last, dbg_state
  );
endinterface

// File: rtl/trig_capture.sv
// Trigger-window capture: circular sample store, level-crossing trigger, oldest-first readout.
// Optional FORCE_TRIG_EN adds a manual trigger input (force_trig) with a pending flag.
module trig_capture #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input logic           clk,
  input logic           rst_n,
  trig_capture_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = '0;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LAST_CNT = (DEPTH_LOG2+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_WAIT    = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] pt_q, pt_d;
  logic [DEPTH_LOG2-1:0] pf_cnt_q, pf_cnt_d;
  logic [DEPTH_LOG2-1:0] post_cnt_q, post_cnt_d;
  logic [DEPTH_LOG2-1:0] trig_addr_q, trig_addr_d;
  logic [DEPTH_LOG2-1:0] rd_addr_q, rd_addr_d;
  logic [DEPTH_LOG2:0]   rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]     prev_q, prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;

  logic                  arm_go, wr_en, level_hit, force_hit, trig_hit, rd_go;
  logic [DEPTH_LOG2-1:0] post_init;

`ifdef FORCE_TRIG_EN
  logic pend_q, pend_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (bus.arm) state_d = (bus.pretrig != PTR_ZERO) ? S_PREFILL : S_WAIT;
      S_PREFILL:      if (wr_en && ((pf_cnt_q + PTR_ONE) == pt_q)) state_d = S_WAIT;
      S_WAIT:         if (trig_hit) state_d = (post_init == PTR_ZERO) ? S_DONE : S_POST;
      S_POST:         if (wr_en && (post_cnt_q == PTR_ONE)) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    arm_go    = bus.arm && ((state_q == S_IDLE) || (state_q == S_DONE));
    wr_en     = bus.sample_valid &&
                ((state_q == S_PREFILL) || (state_q == S_WAIT) || (state_q == S_POST));
    level_hit = prev_valid_q &&
                (bus.trig_falling ? ((prev_q >= bus.trig_level) && (bus.adc_data <  bus.trig_level))
                                  : ((prev_q <  bus.trig_level) && (bus.adc_data >= bus.trig_level)));
`ifdef FORCE_TRIG_EN
    force_hit = bus.force_trig || pend_q;
`else
    force_hit = 1'b0;
`endif
    trig_hit  = (state_q == S_WAIT) && bus.sample_valid && (level_hit || force_hit);
    rd_go     = (state_q == S_DONE) && bus.rd_en && !bus.arm && !rd_cnt_q[DEPTH_LOG2];
    // DEPTH - pt - 1 is the bitwise complement of pt within the pointer width
    post_init = ~pt_q;
  end

  assign bus.busy      = (state_q == S_PREFILL) || (state_q == S_WAIT) || (state_q == S_POST);
  assign bus.triggered = (state_q == S_POST) || (state_q == S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.dbg_state = state_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    pt_d         = pt_q;
    pf_cnt_d     = pf_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_addr_d  = trig_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_cnt_d     = rd_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    rd_valid_d   = rd_go;
    rd_last_d    = rd_go && (rd_cnt_q == LAST_CNT);

    if (arm_go) begin
      pt_d         = bus.pretrig;
      pf_cnt_d     = '0;
      prev_valid_d = 1'b0;
    end
    if (wr_en) begin
      wr_ptr_d     = wr_ptr_q + PTR_ONE;
      prev_d       = bus.adc_data;
      prev_valid_d = 1'b1;
    end
    if (wr_en && (state_q == S_PREFILL)) pf_cnt_d = pf_cnt_q + PTR_ONE;
    if (trig_hit) begin
      trig_addr_d = wr_ptr_q;
      post_cnt_d  = post_init;
    end
    if (wr_en && (state_q == S_POST)) post_cnt_d = post_cnt_q - PTR_ONE;
    // Window starts pt samples before the trigger; trig_addr_d covers the zero-postfill case
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      rd_addr_d = trig_addr_d - pt_q;
      rd_cnt_d  = '0;
    end
    if (rd_go) begin
      rd_addr_d = rd_addr_q + PTR_ONE;
      rd_cnt_d  = rd_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      pt_q         <= '0;
      pf_cnt_q     <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      rd_addr_q    <= '0;
      rd_cnt_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      pt_q         <= pt_d;
      pf_cnt_q     <= pf_cnt_d;
      post_cnt_q   <= post_cnt_d;
      trig_addr_q  <= trig_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_cnt_q     <= rd_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.adc_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data_q <= '0;
    else if (rd_go) rd_data_q <= mem[rd_addr_q];
  end

`ifdef FORCE_TRIG_EN
  // A force request seen during prefill is remembered until the first waiting sample
  always_comb begin
    pend_d = pend_q;
    if ((state_q == S_PREFILL) && bus.force_trig) pend_d = 1'b1;
    if (trig_hit || arm_go)                       pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end
`endif
endmodule

// File: tb/tb_trig_capture.sv
// Directed-plus-random bench for trig_capture with a sample-array reference model.
module tb_trig_capture;
  localparam int DW    = 8;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic clk;
  logic rst_n;

  trig_capture_if #(.DATA_W(DW), .DEPTH_LOG2(DL)) bus ();

  trig_capture #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] exp_q[$];
  int          cur_pt;
  logic [DW-1:0] cur_lvl;
  logic        cur_fall;
  int          rd_idx;

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic bit crosses(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] lvl, input logic fall);
    return fall ? ((a >= lvl) && (b < lvl)) : ((a < lvl) && (b >= lvl));
  endfunction

  // Reference: sample k (index since arm) triggers if k >= pt, k >= 1 and it crosses;
  // the window is samples k-pt .. k-pt+DEPTH-1; capture ends on sample k-pt+DEPTH-1.
  task automatic model_window(input int pt, input logic [DW-1:0] lvl, input logic fall,
                              output int k_trig, output int k_end);
    k_trig = -1;
    for (int k = (pt > 0 ? pt : 1); k < stim_q.size(); k++) begin
      if (crosses(stim_q[k-1], stim_q[k], lvl, fall)) begin
        k_trig = k;
        break;
      end
    end
    k_end = (k_trig < 0) ? -1 : k_trig + DEPTH - 1 - pt;
    exp_q.delete();
    if ((k_trig >= 0) && (k_end < stim_q.size()))
      for (int j = 0; j < DEPTH; j++) exp_q.push_back(stim_q[k_trig - pt + j]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_bit({tag, "_busy"},     bus.busy,      1'b0);
    check_bit({tag, "_trig"},     bus.triggered, 1'b0);
    check_bit({tag, "_done"},     bus.done,      1'b0);
    check_bit({tag, "_rd_valid"}, bus.rd_valid,  1'b0);
    check_bit({tag, "_rd_last"},  bus.rd_last,   1'b0);
    check_byte({tag, "_rd_data"}, bus.rd_data,   8'h00);
  endtask

  task automatic clear_inputs();
    bus.adc_data     = '0;
    bus.sample_valid = 1'b0;
    bus.arm          = 1'b0;
    bus.trig_level   = '0;
    bus.trig_falling = 1'b0;
    bus.pretrig      = '0;
    bus.rd_en        = 1'b0;
`ifdef FORCE_TRIG_EN
    bus.force_trig   = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic arm_pulse(input int pt, input logic [DW-1:0] lvl, input logic fall, input logic with_rd);
    bus.pretrig      = DL'(pt);
    bus.trig_level   = lvl;
    bus.trig_falling = fall;
    bus.arm          = 1'b1;
    bus.rd_en        = with_rd;
    @(negedge clk);
    bus.arm   = 1'b0;
    bus.rd_en = 1'b0;
    cur_pt   = pt;
    cur_lvl  = lvl;
    cur_fall = fall;
    rd_idx   = 0;
    exp_q.delete();
    check_bit("arm_busy",     bus.busy,      1'b1);
    check_bit("arm_done",     bus.done,      1'b0);
    check_bit("arm_trig",     bus.triggered, 1'b0);
    check_bit("arm_rd_valid", bus.rd_valid,  1'b0);
  endtask

  // Feeds stim_q (up to stop_at), optionally pulsing arm on sample arm_at.
  task automatic run_capture(input logic rand_gap, input int arm_at, input int stop_at);
    int k_trig, k_end, last, gap;
    model_window(cur_pt, cur_lvl, cur_fall, k_trig, k_end);
    last = (stop_at >= 0) ? stop_at : stim_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      gap = rand_gap ? int'($urandom_range(0, 3)) : 2;
      repeat (gap) @(negedge clk);
      bus.adc_data     = stim_q[i];
      bus.sample_valid = 1'b1;
      if (i == arm_at) begin
        bus.arm     = 1'b1;
        bus.pretrig = DL'($urandom_range(0, DEPTH - 1));
      end
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.arm          = 1'b0;
      bus.adc_data     = 8'($urandom_range(0, 255));
      check_bit("cap_busy", bus.busy,      (k_end < 0) || (i < k_end));
      check_bit("cap_trig", bus.triggered, (k_trig >= 0) && (i >= k_trig));
      check_bit("cap_done", bus.done,      (k_end >= 0) && (i >= k_end));
    end
  endtask

  task automatic read_n(input int n, input logic rand_gap);
    logic [DW-1:0] e;
    int g;
    for (int j = 0; j < n; j++) begin
      bus.rd_en = 1'b1;
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check_bit("rd_valid", bus.rd_valid, 1'b1);
      check_byte("rd_data", bus.rd_data,  e);
      check_bit("rd_last",  bus.rd_last,  rd_idx == DEPTH - 1);
      rd_idx++;
      if (rand_gap) begin
        g = int'($urandom_range(0, 2));
        bus.rd_en = 1'b0;
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          check_bit("rd_idle", bus.rd_valid, 1'b0);
        end
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic read_extra();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check_bit("extra_rd_valid", bus.rd_valid, 1'b0);
    check_bit("extra_rd_last",  bus.rd_last,  1'b0);
  endtask

  task automatic gen_random_stream();
    int kt, ke;
    for (int t = 0; t < 50; t++) begin
      stim_q.delete();
      for (int i = 0; i < 80; i++) stim_q.push_back(8'($urandom_range(0, 255)));
      model_window(cur_pt, cur_lvl, cur_fall, kt, ke);
      if ((kt >= 0) && (ke < stim_q.size())) break;
    end
  endtask

  task automatic random_capture(input logic arm_with_rd);
    arm_pulse(int'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(48, 208)),
              1'($urandom_range(0, 1)), arm_with_rd);
    gen_random_stream();
    run_capture(1'b1, -1, -1);
    read_n(DEPTH, 1'b1);
    read_extra();
  endtask

  initial begin
    do_reset();
    check_idle_outputs("reset");

    // Ramp, rising at 0x80, pt=4, strobe every third cycle, back-to-back readout
    stim_q.delete();
    for (int i = 0; i < 22; i++) stim_q.push_back(8'(i * 16));
    arm_pulse(4, 8'h80, 1'b0, 1'b0);
    run_capture(1'b0, -1, -1);
    read_n(DEPTH, 1'b0);
    read_extra();

    // Falling at 0x40: 0x40 itself must not trigger, 0x3F must
    stim_q = '{8'h60, 8'h50, 8'h40, 8'h3F};
    for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    arm_pulse(3, 8'h40, 1'b1, 1'b0);
    run_capture(1'b1, -1, -1);
    read_n(DEPTH, 1'b1);

    // pt=0: no trigger on the first sample after arm
    stim_q = '{8'hFF, 8'h00, 8'h20};
    for (int i = 0; i < 17; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    arm_pulse(0, 8'h10, 1'b0, 1'b0);
    run_capture(1'b1, -1, -1);
    read_n(DEPTH, 1'b1);

    // pt=DEPTH-1: trigger sample closes the window
    stim_q.delete();
    for (int i = 0; i < 14; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    stim_q.push_back(8'($urandom_range(0, 127)));
    stim_q.push_back(8'($urandom_range(128, 255)));
    for (int i = 0; i < 3; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    arm_pulse(DEPTH - 1, 8'h80, 1'b0, 1'b0);
    run_capture(1'b1, -1, -1);
    read_n(DEPTH, 1'b0);
    read_extra();

    // Asynchronous reset in the middle of post-fill
    stim_q = '{8'h00, 8'h10, 8'h20, 8'h90};
    for (int i = 0; i < 20; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    arm_pulse(2, 8'h80, 1'b0, 1'b0);
    run_capture(1'b1, -1, 6);
    check_bit("pre_rst_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");
    random_capture(1'b0);

    // arm during WAIT_TRIG is ignored; arm+rd_en in DONE restarts capture
    stim_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h90};
    for (int i = 0; i < 14; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    arm_pulse(2, 8'h80, 1'b0, 1'b0);
    run_capture(1'b1, 3, -1);
    read_n(5, 1'b1);
    random_capture(1'b1);

    // Random captures
    for (int r = 0; r < 4; r++) random_capture(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trig_capture.md
Name: trig_capture

Overview:
- Sample-capture stage directly downstream of the ADC acquisition/decimation stage.
- Takes the decimated 8-bit sample stream and its one-cycle strobe, and stores samples in a circular buffer.
- Detects a level-crossing trigger and freezes a window of DEPTH samples with a programmable pre-trigger count.
- Provides sequential readout of the window, oldest sample first, for the host-interface logic.

Parameters:
DATA_W, 8, sample width in bits
DEPTH_LOG2, 10, log2 of capture depth; DEPTH = 2**DEPTH_LOG2

Ports:
clk  in  1  sample clock, the same clock that drives the acquisition stage
rst_n  in  1  asynchronous active-low reset
adc_data  in  DATA_W  decimated sample
sample_valid  in  1  one-cycle strobe; adc_data is valid in the cycle it is high (the decim_clk strobe)
arm  in  1  single-cycle pulse that starts a capture
trig_level  in  DATA_W  unsigned trigger threshold
trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
pretrig  in  DEPTH_LOG2  samples kept before the trigger sample; latched on arm
busy  out  1  high from arm until capture completes
triggered  out  1  high from trigger detection until the next arm
done  out  1  capture complete, buffer readable
rd_en  in  1  request next readout sample
rd_data  out  DATA_W  readout sample
rd_valid  out  1  rd_data is valid
rd_last  out  1  qualifies the final (DEPTH-th) readout sample

Behaviour:
- Reset: state IDLE; busy, triggered, done, rd_valid, rd_last = 0; rd_data = 0; all pointers and counters = 0. Buffer contents are undefined.
- Clock and reset:
  - One clock domain. Reset is asynchronous assert and synchronous deassert, handled by the reset provided.
  - Reset mid-capture or mid-readout aborts immediately to IDLE.
- Writes:
  - One buffer write at wr_ptr per sample_valid cycle, in states PREFILL, WAIT_TRIG and POSTFILL only.
  - wr_ptr increments modulo DEPTH and wraps freely.
- State machine:
  - IDLE: arm -> latch pretrig as pt. Go to PREFILL if pt > 0, else WAIT_TRIG. Set busy = 1; clear done and triggered; clear prev_valid.
  - PREFILL: count written samples. When the count reaches pt, go to WAIT_TRIG.
  - WAIT_TRIG:
    - On each valid sample, evaluate the trigger against prev (the previous valid sample), then update prev.
    - Rising trigger: prev < trig_level and cur >= trig_level.
    - Falling trigger: prev >= trig_level and cur < trig_level.
    - No trigger is evaluated while prev_valid = 0, i.e. on the first sample after arm.
    - On trigger: trig_addr = wr_ptr of the trigger sample; triggered = 1; post_cnt = DEPTH - pt - 1.
    - If post_cnt = 0, go to DONE in the next cycle; otherwise go to POSTFILL.
  - POSTFILL: decrement post_cnt per valid sample. At 0, go to DONE.
  - DONE:
    - busy = 0, done = 1.
    - rd_addr = (trig_addr - pt) mod DEPTH; rd_cnt = 0.
- Sample comparison and window content:
  - prev tracks every valid sample from arm onward, including PREFILL.
  - The trigger sample is stored at index pt of the readout sequence.
  - In PREFILL, the count is of samples written since arm. Stale pre-arm data is never read out.
- Readout (DONE only):
  - rd_en with rd_cnt < DEPTH -> the next cycle gives rd_valid = 1 and rd_data = mem[rd_addr]; rd_addr increments modulo DEPTH and rd_cnt increments.
  - rd_last = 1 with the DEPTH-th sample.
  - rd_en when rd_cnt = DEPTH, or outside DONE, is ignored (rd_valid stays 0).
  - Back-to-back rd_en gives one sample per cycle.
- Arm handling and simultaneous events:
  - arm in PREFILL, WAIT_TRIG or POSTFILL is ignored.
  - arm in DONE restarts the capture (as from IDLE) and discards any remaining readout.
  - arm and rd_en in the same DONE cycle: arm wins and no read occurs.
  - sample_valid with no arm in IDLE or DONE: no write.
- Range limits: pretrig values >= DEPTH are impossible by width. pt = DEPTH-1 gives a window that ends with the trigger sample.

Optional Feature:
- Macro: FORCE_TRIG_EN.
- Defined:
  - Adds input force_trig (1 bit).
  - force_trig high in WAIT_TRIG on a sample_valid cycle is treated as a trigger on that sample, regardless of level or prev_valid.
  - force_trig high in PREFILL is held pending and fires on the first valid sample in WAIT_TRIG.
  - The pending flag is cleared on arm and on reset.
- Undefined: no port; triggers come from level crossings only.

Test Plan:
- DEPTH_LOG2=4, pt=4, rising, level 0x80, ramp 0x00,0x10,... strobed every 3rd cycle -> triggered on 0x80. Readout = 0x40,0x50,0x60,0x70,0x80,... (16 samples), rd_last on the 16th.
- Falling, level 0x40, samples 0x60,0x50,0x40,0x3F -> trigger on 0x3F, not on 0x40. Sample 0x3F at readout index pt.
- pt=0, first sample after arm 0xFF with level 0x10 -> no trigger on the first sample. Next 0x00 then 0x20 -> trigger on 0x20, which is readout index 0.
- pt=15 -> done one cycle after the trigger sample. The trigger sample is the last readout sample, with rd_last = 1.
- rst_n low during POSTFILL -> all outputs return to reset values immediately. A subsequent arm captures correctly. A 17th rd_en after rd_last produces no rd_valid.
- arm pulsed in WAIT_TRIG -> ignored. arm with rd_en in DONE after 5 reads -> new capture starts, busy=1, done=0, rd_valid=0.
